mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-002 SHALL have port clk_CPU  in  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_CPU_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports opcode  in  6 and funct  in  6: IR[31:26] and IR[5:0] from the datapath.
REQ-005 SHALL have port zero  in  1: ALU zero flag.
REQ-006 SHALL have 1-bit outputs pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, halted, instr_done.
REQ-007 SHALL have 2-bit outputs alu_src_b, alu_op and pc_source.
REQ-008 SHALL have outputs state  out  4 (current state code), cycle_count  out  CNT_W and instr_count  out  CNT_W.

Function
REQ-009 SHALL be a registered-state Moore FSM; control outputs decode from state only, except pc_en and the REQ-024 gating.
REQ-010 SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, HALT=12.
REQ-011 SHALL transition FETCH->DECODE; DECODE by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EX, any other->HALT.
REQ-012 SHALL transition MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXEC->ALUWB; ADDI_EX->ADDI_WB; MEMWB, MEMWR, ALUWB, ADDI_WB, BRANCH, JUMP->FETCH; HALT->HALT.
REQ-013 SHALL drive FETCH: mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
REQ-014 SHALL drive DECODE: alu_src_b=11. MEMADR and ADDI_EX: alu_src_a=1, alu_src_b=10.
REQ-015 SHALL drive MEMRD: mem_read=1, i_or_d=1. MEMWR: mem_write=1, i_or_d=1. MEMWB: reg_write=1, mem_to_reg=1.
REQ-016 SHALL drive EXEC: alu_src_a=1, alu_op=10. ALUWB: reg_write=1, reg_dst=1. ADDI_WB: reg_write=1.
REQ-017 SHALL drive BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. JUMP: pc_write=1, pc_source=10.
REQ-018 SHALL drive every output not listed for a state to 0, including all outputs in HALT; halted=1 only in HALT.
REQ-019 SHALL compute pc_en = pc_write | (pc_write_cond & zero) combinationally.
REQ-020 SHALL pulse instr_done for one cycle in each state that returns to FETCH.
REQ-021 SHALL give latencies, counted FETCH to last state inclusive: lw 5, sw/R/addi 4, beq/j 3 cycles.
REQ-022 SHALL increment cycle_count every non-HALT cycle and instr_count on every instr_done; both wrap from 2^CNT_W-1 to 0.

Reset
REQ-023 SHALL, with rst_CPU_n=0 at a clock edge, set state=FETCH and clear both counters regardless of current state, including mid-instruction and HALT; the first FETCH follows the first edge with rst_CPU_n=1.

Configuration
REQ-024 SHALL, with MC_MEM_WAIT_EN defined, add input mem_ready (1 bit); FETCH, MEMRD and MEMWR hold while mem_ready=0, with ir_write, pc_write, reg-side effects and instr_done gated by mem_ready; mem_read/mem_write stay asserted.
REQ-025 SHALL, without MC_MEM_WAIT_EN, omit the mem_ready port and behave as if mem_ready=1.

Structure
REQ-026 SHALL place state encodings, opcode constants (R, LW, SW, BEQ, J, ADDI) and alu_op/alu_src_b/pc_source codes in shared package mips_ctrl_pkg.
REQ-027 SHALL implement the counters in sub-module perf_counter, instantiated twice; no other sub-modules.

Verification
REQ-028 SHALL verify reset: hold rst_CPU_n=0 for 2 cycles -> state=0, cycle_count=0, instr_count=0; release -> DECODE on the next edge.
REQ-029 SHALL verify lw: opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in state 4; instr_count=1 after 5 cycles.
REQ-030 SHALL verify beq: opcode=000100 with zero=1 -> pc_en=1 in BRANCH; with zero=0 -> pc_en=0; return to FETCH in both cases.
REQ-031 SHALL verify illegal: opcode=111111 -> HALT, halted=1, all controls 0, cycle_count frozen for 10 cycles; rst_CPU_n=0 -> FETCH.
REQ-032 SHALL verify wrap: CNT_W=4 with 16 R-type instructions -> instr_count returns to 0.
REQ-033 SHALL verify MC_MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH -> state held at 0, ir_write=0; mem_ready=1 -> ir_write=1 and DECODE next.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// datapath select codes and the per-state control word decode.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       halted;
    logic       instr_done;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Moore decode: every field not set for a state stays zero.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    c.alu_src_b = SRCB_REG;
    c.alu_op    = ALUOP_ADD;
    c.pc_source = PCSRC_ALU;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: c.alu_src_b = SRCB_BRANCH;
      S_MEMADR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter with synchronous active-low clear.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with cycle/instruction counters.
// Define MC_MEM_WAIT_EN to add a mem_ready handshake stalling FETCH/MEMRD/MEMWR.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_CPU,
  input  logic             rst_CPU_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
`ifdef MC_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             halted,
  output logic             instr_done,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_t cur, nxt;
  ctrl_t  ctrl_q;
  logic   mem_rdy;
  logic   wait_st;
  logic   go;
  logic   unused_funct;

`ifdef MC_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // The control unit only needs the opcode; funct is consumed by the ALU decoder.
  assign unused_funct = ^funct;

  assign wait_st = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  assign go      = mem_rdy || !wait_st;

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  nxt = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:         nxt = S_EXEC;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDI_EX;
          default:      nxt = S_HALT;
        endcase
      end
      S_MEMADR:  nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   nxt = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   nxt = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:    nxt = S_ALUWB;
      S_ADDI_EX: nxt = S_ADDI_WB;
      S_MEMWB, S_ALUWB, S_ADDI_WB, S_BRANCH, S_JUMP: nxt = S_FETCH;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_HALT;
    endcase
  end

  // Control word is registered alongside the state so outputs are glitch-free.
  always_ff @(posedge clk_CPU) begin
    if (!rst_CPU_n) begin
      cur    <= S_FETCH;
      ctrl_q <= decode_state(S_FETCH);
    end else begin
      cur    <= nxt;
      ctrl_q <= decode_state(nxt);
    end
  end

  assign pc_write      = ctrl_q.pc_write & go;
  assign ir_write      = ctrl_q.ir_write & go;
  assign reg_write     = ctrl_q.reg_write & go;
  assign instr_done    = ctrl_q.instr_done & go;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign halted        = ctrl_q.halted;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign pc_en         = pc_write | (pc_write_cond & zero);
  assign state         = cur;

  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk_CPU),
    .rst_n (rst_CPU_n),
    .inc   (cur != S_HALT),
    .count (cycle_count)
  );

  perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk_CPU),
    .rst_n (rst_CPU_n),
    .inc   (instr_done),
    .count (instr_count)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed plus randomized check of the multicycle control FSM against a
// per-instruction state-sequence model; honours MC_MEM_WAIT_EN when defined.
module tb_mips_multicycle_control;

  localparam int CNT_W = 4;
  localparam int MODV  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_CPU_n = 1'b0;
  logic [5:0]       opcode = 6'd0;
  logic [5:0]       funct = 6'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b1;
  logic             pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write;
  logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, halted, instr_done;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic [CNT_W-1:0] cycle_count, instr_count;

  mips_multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk_CPU       (clk),
    .rst_CPU_n     (rst_CPU_n),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
`ifdef MC_MEM_WAIT_EN
    .mem_ready     (mem_ready),
`endif
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_en         (pc_en),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .halted        (halted),
    .instr_done    (instr_done),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .cycle_count   (cycle_count),
    .instr_count   (instr_count)
  );

  int checks = 0;
  int failures = 0;
  int exp_cyc = 0;
  int exp_ins = 0;
  int zero_mode = -1;  // -1: random zero flag, else forced value

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control word from the per-state output rules; go=0 models a memory stall.
  function automatic logic [17:0] exp_ctrl(input int s, input logic go);
    logic pcw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, hlt, dn;
    logic [1:0] bsrc, aop, psrc;
    {pcw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, hlt, dn} = 12'd0;
    bsrc = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin mrd = 1'b1; irw = go; pcw = go; bsrc = 2'b01; end
      1:  bsrc = 2'b11;
      2, 10: begin asa = 1'b1; bsrc = 2'b10; end
      3:  begin mrd = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
      5:  begin mwr = 1'b1; iod = 1'b1; dn = go; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rdst = 1'b1; dn = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; dn = 1'b1; end
      9:  begin pcw = 1'b1; psrc = 2'b10; dn = 1'b1; end
      11: begin rw = 1'b1; dn = 1'b1; end
      12: hlt = 1'b1;
      default: ;
    endcase
    return {pcw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, hlt, dn, bsrc, aop, psrc};
  endfunction

  function automatic logic [17:0] dut_ctrl();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, halted, instr_done, alu_src_b, alu_op, pc_source};
  endfunction

  // Check one expected state; repeats while a memory stall holds it.
  task automatic run_state(input int s);
    logic [17:0] ec;
    logic waiting;
    logic go;
    int n;
    n = 0;
    do begin
`ifdef MC_MEM_WAIT_EN
      mem_ready = ($urandom_range(3) != 0);
`endif
      zero = (zero_mode < 0) ? 1'($urandom_range(1)) : 1'(zero_mode);
      #1;
      go = mem_ready || !(s == 0 || s == 3 || s == 5);
      ec = exp_ctrl(s, go);
      check("state", 32'(state), 32'(s));
      check("ctrl", 32'(dut_ctrl()), 32'(ec));
      check("pc_en", 32'(pc_en), 32'(ec[17] | (ec[16] & zero)));
      check("cycle_count", 32'(cycle_count), 32'(exp_cyc));
      check("instr_count", 32'(instr_count), 32'(exp_ins));
      @(posedge clk); #1;
      if (s != 12) exp_cyc = (exp_cyc + 1) % MODV;
      if (ec[6]) exp_ins = (exp_ins + 1) % MODV;
      waiting = !go;
      n++;
    end while (waiting && n < 50);
  endtask

  task automatic run_instr(input logic [5:0] op);
    int seq[$];
    opcode = op;
    funct = 6'($urandom);
    case (op)
      6'b000000: seq = '{0, 1, 6, 7};
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 9};
      6'b001000: seq = '{0, 1, 10, 11};
      default:   seq = '{0, 1, 12};
    endcase
    foreach (seq[i]) run_state(seq[i]);
  endtask

  task automatic do_reset();
    rst_CPU_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_cyc = 0;
    exp_ins = 0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cycle", 32'(cycle_count), 32'd0);
    check("rst_instr", 32'(instr_count), 32'd0);
    rst_CPU_n = 1'b1;
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [3:0] frozen;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

    // Reset then release: DECODE on the first edge with reset high.
    do_reset();
    opcode = 6'b000000;
    @(posedge clk); #1;
    check("release_decode", 32'(state), 32'd1);
    check("release_cycle", 32'(cycle_count), 32'd1);

    // Reset mid-instruction, then a load.
    do_reset();
    run_instr(6'b100011);
    check("lw_instr_count", 32'(instr_count), 32'd1);

    // Branch taken and not taken.
    zero_mode = 1; run_instr(6'b000100);
    zero_mode = 0; run_instr(6'b000100);
    zero_mode = -1;

    // Illegal opcode halts, counters freeze, reset recovers.
    run_instr(6'b111111);
    frozen = cycle_count;
    repeat (10) run_state(12);
    check("halt_frozen", 32'(cycle_count), 32'(frozen));
    do_reset();

    // Counter wrap with 16 R-type instructions.
    repeat (16) run_instr(6'b000000);
    check("wrap_instr", 32'(instr_count), 32'd0);

    // Randomized instruction mix.
    for (int i = 0; i < 40; i++) run_instr(ops[$urandom_range(5)]);

`ifdef MC_MEM_WAIT_EN
    do_reset();
    opcode = 6'b000000;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait_state", 32'(state), 32'd0);
      check("wait_ir_write", 32'(ir_write), 32'd0);
      check("wait_mem_read", 32'(mem_read), 32'd1);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #1;
    check("ready_ir_write", 32'(ir_write), 32'd1);
    @(posedge clk); #1;
    check("ready_decode", 32'(state), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
